// File: rtl/matrix_mac_engine.sv
// matrix_mac_engine: sequential matrix multiplier C = A x B built around one
// multiply-accumulate datapath. Operands and the signed/unsigned mode are
// captured at start. Each output element is scaled by FRAC_BITS, saturated
// to WIDTH_BIT and written into MatrixO as soon as it is complete.
module matrix_mac_engine #(
    parameter int AROWS     = 3,
    parameter int ACOLUMNS  = 3,
    parameter int BROWS     = 3,
    parameter int BCOLUMNS  = 3,
    parameter int WIDTH_BIT = 32,
    parameter int ACC_WIDTH = 2*WIDTH_BIT + $clog2(ACOLUMNS) + 1,
    parameter int FRAC_BITS = 0
) (
    input  logic                                          clock,
    input  logic                                          reset,
    input  logic                                          start,
    input  logic                                          signed_mode,
    input  logic [AROWS-1:0][ACOLUMNS-1:0][WIDTH_BIT-1:0] MatrixA,
    input  logic [BROWS-1:0][BCOLUMNS-1:0][WIDTH_BIT-1:0] MatrixB,
    output logic [AROWS-1:0][BCOLUMNS-1:0][WIDTH_BIT-1:0] MatrixO,
    output logic                                          busy,
    output logic                                          done,
    output logic                                          saturated
);

    // Inner dimensions must agree; stop elaboration otherwise.
    if (ACOLUMNS != BROWS) begin : g_dim_check
        $error("matrix_mac_engine: ACOLUMNS must equal BROWS");
    end

    localparam int IW = (AROWS    > 1) ? $clog2(AROWS)    : 1;
    localparam int JW = (BCOLUMNS > 1) ? $clog2(BCOLUMNS) : 1;
    localparam int KW = (ACOLUMNS > 1) ? $clog2(ACOLUMNS) : 1;
    localparam logic [IW-1:0] I_LAST = IW'(AROWS - 1);
    localparam logic [JW-1:0] J_LAST = JW'(BCOLUMNS - 1);
    localparam logic [KW-1:0] K_LAST = KW'(ACOLUMNS - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_MAC   = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t state_r, state_nx_s;

    logic [AROWS-1:0][ACOLUMNS-1:0][WIDTH_BIT-1:0] a_r;
    logic [BROWS-1:0][BCOLUMNS-1:0][WIDTH_BIT-1:0] b_r;
    logic [AROWS-1:0][BCOLUMNS-1:0][WIDTH_BIT-1:0] matrix_o_r;
    logic                 mode_r;
    logic [IW-1:0]        i_r;
    logic [JW-1:0]        j_r;
    logic [KW-1:0]        k_r;
    logic [ACC_WIDTH-1:0] acc_r;
    logic                 busy_r, done_r, saturated_r;
    logic                 busy_s, done_s;

    logic [WIDTH_BIT-1:0]        a_elem_s, b_elem_s;
    logic [ACC_WIDTH-1:0]        a_ext_s, b_ext_s, prod_s;
    logic signed [ACC_WIDTH-1:0] acc_sra_s;
    logic [ACC_WIDTH-1:0]        acc_srl_s, shifted_s;
    logic [WIDTH_BIT:0]          sat_s;

    // Clip a scaled accumulator value into WIDTH_BIT; MSB of the result flags a clip.
    function automatic logic [WIDTH_BIT:0] sat_fn(input logic [ACC_WIDTH-1:0] r,
                                                  input logic sgn);
        logic [WIDTH_BIT:0] res;
        res = {1'b0, r[WIDTH_BIT-1:0]};
        if (sgn) begin
            if (r[ACC_WIDTH-1:WIDTH_BIT-1] != {(ACC_WIDTH-WIDTH_BIT+1){r[ACC_WIDTH-1]}}) begin
                res = r[ACC_WIDTH-1] ? {1'b1, 1'b1, {(WIDTH_BIT-1){1'b0}}}
                                     : {1'b1, 1'b0, {(WIDTH_BIT-1){1'b1}}};
            end else begin
                res = {1'b0, r[WIDTH_BIT-1:0]};
            end
        end else begin
            if (r[ACC_WIDTH-1:WIDTH_BIT] != {(ACC_WIDTH-WIDTH_BIT){1'b0}}) begin
                res = {1'b1, {WIDTH_BIT{1'b1}}};
            end else begin
                res = {1'b0, r[WIDTH_BIT-1:0]};
            end
        end
        return res;
    endfunction

    // Operand selection, extension to accumulator width and the product term.
    assign a_elem_s  = a_r[i_r][k_r];
    assign b_elem_s  = b_r[k_r][j_r];
    assign a_ext_s   = mode_r ? {{(ACC_WIDTH-WIDTH_BIT){a_elem_s[WIDTH_BIT-1]}}, a_elem_s}
                              : {{(ACC_WIDTH-WIDTH_BIT){1'b0}}, a_elem_s};
    assign b_ext_s   = mode_r ? {{(ACC_WIDTH-WIDTH_BIT){b_elem_s[WIDTH_BIT-1]}}, b_elem_s}
                              : {{(ACC_WIDTH-WIDTH_BIT){1'b0}}, b_elem_s};
    assign prod_s    = a_ext_s * b_ext_s;
    // Shifts are kept in separate signals so the arithmetic one stays signed.
    assign acc_sra_s = $signed(acc_r) >>> FRAC_BITS;
    assign acc_srl_s = acc_r >> FRAC_BITS;
    assign shifted_s = mode_r ? acc_sra_s : acc_srl_s;
    assign sat_s     = sat_fn(shifted_s, mode_r);

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE:  state_nx_s = start ? ST_LOAD : ST_IDLE;
            ST_LOAD:  state_nx_s = ST_MAC;
            ST_MAC:   state_nx_s = (k_r == K_LAST) ? ST_WRITE : ST_MAC;
            ST_WRITE: state_nx_s = ((i_r == I_LAST) && (j_r == J_LAST)) ? ST_DONE : ST_MAC;
            ST_DONE:  state_nx_s = ST_IDLE;
            default:  state_nx_s = ST_IDLE;
        endcase
    end

    // Output decode from the upcoming state so busy/done can be registered.
    always_comb begin
        busy_s = 1'b0;
        done_s = 1'b0;
        case (state_nx_s)
            ST_IDLE: begin
                busy_s = 1'b0;
                done_s = 1'b0;
            end
            ST_DONE: begin
                busy_s = 1'b1;
                done_s = 1'b1;
            end
            default: begin
                busy_s = 1'b1;
                done_s = 1'b0;
            end
        endcase
    end

    // Registered handshake outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= busy_s;
            done_r <= done_s;
        end
    end

    // Datapath: operand capture, accumulation, element write-back and index walk.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_r         <= '0;
            b_r         <= '0;
            mode_r      <= 1'b0;
            i_r         <= '0;
            j_r         <= '0;
            k_r         <= '0;
            acc_r       <= '0;
            matrix_o_r  <= '0;
            saturated_r <= 1'b0;
        end else begin
            case (state_r)
                ST_LOAD: begin
                    a_r         <= MatrixA;
                    b_r         <= MatrixB;
                    mode_r      <= signed_mode;
                    i_r         <= '0;
                    j_r         <= '0;
                    k_r         <= '0;
                    acc_r       <= '0;
                    saturated_r <= 1'b0;
                end
                ST_MAC: begin
                    acc_r <= acc_r + prod_s;
                    if (k_r != K_LAST) begin
                        k_r <= k_r + KW'(1);
                    end
                end
                ST_WRITE: begin
                    matrix_o_r[i_r][j_r] <= sat_s[WIDTH_BIT-1:0];
                    if (sat_s[WIDTH_BIT]) begin
                        saturated_r <= 1'b1;
                    end
                    acc_r <= '0;
                    k_r   <= '0;
                    if (j_r == J_LAST) begin
                        j_r <= '0;
                        i_r <= (i_r == I_LAST) ? '0 : i_r + IW'(1);
                    end else begin
                        j_r <= j_r + JW'(1);
                    end
                end
                default: begin
                    acc_r <= acc_r;
                end
            endcase
        end
    end

    assign MatrixO   = matrix_o_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign saturated = saturated_r;

endmodule
